instr_stream_parser: RTL and testbench

Parametrised successor to the single-channel instruction getter. It sits between the DMA AXI-stream FIFO and the core. It parses two-word stream headers and captures a configurable number of 64-bit instruction words into a flat register bank. It routes payload to one of `DCH` data-store channels and raises the start pulse once the master FSM is idle. Unlike the previous generation, it detects malformed headers and short instruction bursts and recovers by draining to `last`.

---
 rtl/instr_stream_pkg.sv | 43 ++++
 rtl/instr_bank.sv | 37 +++
 rtl/instr_stream_parser.sv | 175 +++++++++++++++++
 tb/tb_instr_stream_parser.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_pkg.sv
`default_nettype none
// ============================================================
// Module  : instr_stream_pkg
// Brief   : Stream header constants, parser states and data-header decode.
// Revision: 1.0 - initial release
// ============================================================
package instr_stream_pkg;

  localparam logic [63:0] c_INST_HEAD    = 64'hefef_123a_bbee_ff22;
  localparam logic [59:0] c_DATA_HEAD_HI = 60'hefef_6543_dada_ff1;
  localparam logic [2:0]  M_IDLE         = 3'd0;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_HEAD  = 4'd1,
    ST_CHEK  = 4'd2,
    ST_INST  = 4'd3,
    ST_WAIT  = 4'd4,
    ST_STRT  = 4'd5,
    ST_FLUS  = 4'd6,
    ST_DATA  = 4'd7,
    ST_DRAIN = 4'd8
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] ch;
  } data_head_t;

  // Low nibble carries channel+1, so a zero nibble never names a channel.
  function automatic data_head_t is_data_head(input logic [63:0] word, input int dch);
    data_head_t r;
    r.valid = 1'b0;
    r.ch    = 4'd0;
    if ((word[63:4] == c_DATA_HEAD_HI) && (word[3:0] != 4'd0)) begin
      r.ch    = word[3:0] - 4'd1;
      r.valid = (int'(r.ch) < dch);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_bank.sv
`default_nettype none
// ============================================================
// Module  : instr_bank
// Brief   : INSTR_NUM x 64-bit instruction register file, flat output bus.
// Revision: 1.0 - initial release
// ============================================================
module instr_bank #(
  parameter int INSTR_NUM = 16,
  parameter int IW        = $clog2(INSTR_NUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [IW-1:0]           widx,
  input  logic [63:0]             wdata,
  input  logic                    clr_slot0,
  output logic [INSTR_NUM*64-1:0] bus
);

  for (genvar k = 0; k < INSTR_NUM; k++) begin : g_slot
    logic [63:0] r_slot;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_slot <= '0;
      end else if (clr_slot0 && (k == 0)) begin
        r_slot <= '0;
      end else if (we && (widx == IW'(k))) begin
        r_slot <= wdata;
      end
    end

    assign bus[64*k +: 64] = r_slot;
  end

endmodule
`default_nettype wire

// File: rtl/instr_stream_parser.sv
`default_nettype none
// ============================================================
// Module  : instr_stream_parser
// Brief   : Parses stream headers, captures instruction bursts, routes data channels.
// Revision: 1.0 - initial release
// ============================================================
module instr_stream_parser
  import instr_stream_pkg::*;
#(
  parameter int         TBITS       = 64,
  parameter int         INSTR_NUM   = 16,
  parameter int         DCH         = 2,
  parameter logic [2:0] M_IDLE_CODE = M_IDLE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [TBITS-1:0]        fifo_data_din,
  input  logic                    fifo_last_din,
  input  logic                    fifo_empty_n_din,
  output logic                    fifo_read_dout,
  output logic [DCH-1:0]          ds_empty_n,
  input  logic [DCH-1:0]          ds_read,
  input  logic [2:0]              mast_curr_state,
  output logic [INSTR_NUM*64-1:0] instr_bus,
  output logic                    instr_valid,
  output logic                    start_reg,
  output logic                    busy,
  output logic                    err_hdr,
  output logic                    err_len,
  input  logic                    err_clr
);

  localparam int            IW         = $clog2(INSTR_NUM);
  localparam logic [IW-1:0] c_LAST_IDX = IW'(INSTR_NUM - 1);

  state_t        r_state, w_state_nxt;
  logic [63:0]   r_hd0, r_hd1;
  logic          r_hsel;
  logic [3:0]    r_ch;
  logic [IW-1:0] r_idx;
  logic          r_instr_valid, r_err_hdr, r_err_len;
  logic [DCH-1:0] w_ch_onehot;
  logic          w_ds_read_sel, w_consume, w_last, w_burst_done, w_bank_we;
  logic          w_set_hdr, w_set_len, w_clr_slot0, w_hd_match;
  data_head_t    w_dhead;

  for (genvar c = 0; c < DCH; c++) begin : g_ch
    assign w_ch_onehot[c] = (r_ch == 4'(c));
    assign ds_empty_n[c]  = (r_state == ST_DATA) && w_ch_onehot[c] && fifo_empty_n_din;
  end

  assign w_ds_read_sel = |(ds_read & w_ch_onehot);
  assign w_consume     = fifo_read_dout & fifo_empty_n_din;
  assign w_last        = w_consume & fifo_last_din;
  assign w_hd_match    = (r_hd0 == r_hd1);
  assign w_dhead       = is_data_head(r_hd0, DCH);
  assign w_burst_done  = (r_state == ST_INST) && w_consume && (r_idx == c_LAST_IDX);
  assign w_bank_we     = (r_state == ST_INST) && w_consume;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    fifo_read_dout = 1'b0;
    start_reg      = 1'b0;
    w_set_hdr      = 1'b0;
    w_set_len      = 1'b0;
    w_clr_slot0    = 1'b0;
    case (r_state)
      ST_IDLE: if (fifo_empty_n_din) w_state_nxt = ST_HEAD;
      ST_HEAD: begin
        fifo_read_dout = fifo_empty_n_din;
        if (w_last) begin
          w_set_hdr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_consume && r_hsel) begin
          w_state_nxt = ST_CHEK;
        end
      end
      ST_CHEK: begin
        if (w_hd_match && (r_hd0 == c_INST_HEAD)) begin
          w_state_nxt = ST_INST;
        end else if (w_hd_match && w_dhead.valid) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_set_hdr   = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_INST: begin
        fifo_read_dout = fifo_empty_n_din;
        if (w_burst_done) begin
          w_state_nxt = ST_WAIT;
        end else if (w_last) begin
          w_set_len   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: if (mast_curr_state == M_IDLE_CODE) w_state_nxt = ST_STRT;
      ST_STRT: begin
        start_reg   = instr_bus[63];
        w_state_nxt = ST_FLUS;
      end
      ST_FLUS: begin
        w_clr_slot0 = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_DATA: begin
        fifo_read_dout = w_ds_read_sel;
        if (w_last) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        fifo_read_dout = fifo_empty_n_din;
        if (w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hd0         <= '0;
      r_hd1         <= '0;
      r_hsel        <= 1'b0;
      r_ch          <= '0;
      r_idx         <= '0;
      r_instr_valid <= 1'b0;
      r_err_hdr     <= 1'b0;
      r_err_len     <= 1'b0;
    end else begin
      r_instr_valid <= w_burst_done;
      if (r_state == ST_HEAD) begin
        if (w_consume) begin
          if (!r_hsel) r_hd0 <= fifo_data_din[63:0];
          else         r_hd1 <= fifo_data_din[63:0];
          r_hsel <= ~r_hsel;
        end
      end else begin
        r_hsel <= 1'b0;
      end
      if (r_state == ST_CHEK) r_ch <= w_dhead.ch;
      if (r_state == ST_INST) begin
        if (w_consume) r_idx <= r_idx + 1'b1;
      end else begin
        r_idx <= '0;
      end
      // A new error in the same cycle as a clear keeps the flag set.
      r_err_hdr <= w_set_hdr | (r_err_hdr & ~err_clr);
      r_err_len <= w_set_len | (r_err_len & ~err_clr);
    end
  end

  instr_bank #(
    .INSTR_NUM (INSTR_NUM),
    .IW        (IW)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .we        (w_bank_we),
    .widx      (r_idx),
    .wdata     (fifo_data_din[63:0]),
    .clr_slot0 (w_clr_slot0),
    .bus       (instr_bus)
  );

  assign instr_valid = r_instr_valid;
  assign busy        = (r_state != ST_IDLE);
  assign err_hdr     = r_err_hdr;
  assign err_len     = r_err_len;

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_parser.sv
`default_nettype none
// ============================================================
// Module  : tb_instr_stream_parser
// Brief   : Scoreboard bench for instr_stream_parser (INSTR_NUM=16, DCH=2).
// Revision: 1.0 - initial release
// ============================================================
module tb_instr_stream_parser;

  localparam int          INUM      = 16;
  localparam int          NCH       = 2;
  localparam logic [63:0] INST_HEAD = 64'hefef_123a_bbee_ff22;
  localparam logic [63:0] DH_CH0    = 64'hefef_6543_dada_ff11;
  localparam logic [63:0] DH_CH1    = 64'hefef_6543_dada_ff12;
  localparam logic [63:0] DH_CH2    = 64'hefef_6543_dada_ff13;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [63:0]       fifo_data_din = '0;
  logic              fifo_last_din = 1'b0;
  logic              fifo_empty_n_din = 1'b0;
  logic              fifo_read_dout;
  logic [NCH-1:0]    ds_empty_n;
  logic [NCH-1:0]    ds_read = '0;
  logic [2:0]        mast_curr_state = 3'd1;
  logic [INUM*64-1:0] instr_bus;
  logic              instr_valid, start_reg, busy, err_hdr, err_len;
  logic              err_clr = 1'b0;

  instr_stream_parser #(
    .TBITS       (64),
    .INSTR_NUM   (INUM),
    .DCH         (NCH),
    .M_IDLE_CODE (3'd0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_data_din    (fifo_data_din),
    .fifo_last_din    (fifo_last_din),
    .fifo_empty_n_din (fifo_empty_n_din),
    .fifo_read_dout   (fifo_read_dout),
    .ds_empty_n       (ds_empty_n),
    .ds_read          (ds_read),
    .mast_curr_state  (mast_curr_state),
    .instr_bus        (instr_bus),
    .instr_valid      (instr_valid),
    .start_reg        (start_reg),
    .busy             (busy),
    .err_hdr          (err_hdr),
    .err_len          (err_len),
    .err_clr          (err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit [64:0]          stream_q[$];
  bit [INUM*64-1:0]   exp_bus_q[$];
  bit [63:0]          exp_data_q[$];
  bit [63:0]          model[INUM];
  int                 pop_cyc_q[$];
  int                 cyc = 0, pop_cnt = 0, iv_cnt = 0, st_cnt = 0, iv_cyc = 0;
  bit                 ds0_seen = 0, ds1_seen = 0, gaps = 0, ds_toggle = 0, consume_s = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIFO model and output monitor: sample at negedge, update inputs just after posedge.
  initial begin
    forever begin
      @(negedge clk);
      consume_s = fifo_read_dout & fifo_empty_n_din;
      if (!reset) begin
        if (consume_s) begin
          pop_cnt++;
          pop_cyc_q.push_back(cyc);
        end
        if (ds_empty_n[0]) ds0_seen = 1;
        if (ds_empty_n[1]) ds1_seen = 1;
        if (ds_read[1] && ds_empty_n[1]) begin
          if (exp_data_q.size() == 0) check("data_unexpected", 1, 0);
          else check("data_word", fifo_data_din, exp_data_q.pop_front());
        end
        if (instr_valid) begin
          iv_cnt++;
          iv_cyc = cyc;
          if (exp_bus_q.size() == 0) begin
            check("iv_unexpected", 1, 0);
          end else begin
            bit [INUM*64-1:0] e;
            e = exp_bus_q.pop_front();
            for (int k = 0; k < INUM; k++)
              check($sformatf("iv_slot%0d", k), instr_bus[64*k +: 64], e[64*k +: 64]);
          end
        end
        if (start_reg) st_cnt++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (consume_s && stream_q.size() > 0) void'(stream_q.pop_front());
      ds_read[1] = ds_toggle ? ~ds_read[1] : 1'b0;
      if (stream_q.size() > 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
        fifo_empty_n_din = 1'b1;
        fifo_data_din    = stream_q[0][63:0];
        fifo_last_din    = stream_q[0][64];
      end else begin
        fifo_empty_n_din = 1'b0;
        fifo_data_din    = '0;
        fifo_last_din    = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_word(input bit [63:0] d, input bit last);
    stream_q.push_back({last, d});
  endtask

  task automatic push_burst(input int n, input bit [63:0] w0, output bit [63:0] wlast);
    bit [63:0] w;
    bit [INUM*64-1:0] e;
    push_word(INST_HEAD, 0);
    push_word(INST_HEAD, 0);
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : {$urandom, $urandom};
      push_word(w, k == n - 1);
      model[k] = w;
      wlast = w;
    end
    if (n == INUM) begin
      for (int k = 0; k < INUM; k++) e[64*k +: 64] = model[k];
      exp_bus_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (stream_q.size() == 0 && !busy && !fifo_empty_n_din) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_iv(input int target, input string tag);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (iv_cnt >= target) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    if (!ok) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic clear_counts();
    pop_cnt  = 0;
    pop_cyc_q.delete();
    ds0_seen = 0;
    ds1_seen = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int iv0, st0;
    bit [63:0] wl;
    bit ok;

    tick(3);
    check("rst_busy", busy, 0);
    check("rst_read", fifo_read_dout, 0);
    check("rst_iv", instr_valid, 0);
    check("rst_start", start_reg, 0);
    check("rst_err_hdr", err_hdr, 0);
    check("rst_err_len", err_len, 0);
    check("rst_ds", ds_empty_n, 0);
    check("rst_slot0", instr_bus[63:0], 0);
    check("rst_slot15", instr_bus[INUM*64-1 -: 64], 0);
    reset = 1'b0;
    tick(1);

    // Full burst, master busy for 5 cycles after capture
    clear_counts();
    iv0 = iv_cnt; st0 = st_cnt;
    mast_curr_state = 3'd1;
    push_burst(INUM, 64'h8000_0000_0000_0001, wl);
    wait_iv(iv0 + 1, "burst_iv");
    tick(5);
    check("burst_early_start", st_cnt - st0, 0);
    mast_curr_state = 3'd0;
    wait_done("burst");
    check("burst_iv_cnt", iv_cnt - iv0, 1);
    check("burst_start_cnt", st_cnt - st0, 1);
    check("burst_slot0_flushed", instr_bus[63:0], 0);
    check("burst_slot15", instr_bus[INUM*64-1 -: 64], wl);
    check("burst_pops", pop_cnt, INUM + 2);
    if (pop_cyc_q.size() == INUM + 2) begin
      check("burst_hdr_latency", pop_cyc_q[2] - pop_cyc_q[1], 2);
      check("burst_iv_latency", iv_cyc - pop_cyc_q[INUM + 1], 1);
    end
    model[0] = '0;

    // Data routing to channel 1 with toggling pop request
    clear_counts();
    ds_toggle = 1;
    push_word(DH_CH1, 0);
    push_word(DH_CH1, 0);
    for (int k = 0; k < 4; k++) begin
      wl = {$urandom, $urandom};
      push_word(wl, k == 3);
      exp_data_q.push_back(wl);
    end
    wait_done("data");
    ds_toggle = 0;
    check("data_ds0_seen", ds0_seen, 0);
    check("data_ds1_seen", ds1_seen, 1);
    check("data_pops", pop_cnt, 6);
    check("data_left", exp_data_q.size(), 0);
    check("data_err_hdr", err_hdr, 0);
    check("data_idle", busy, 0);

    // Mismatched header pair is drained
    clear_counts();
    iv0 = iv_cnt;
    push_word(INST_HEAD, 0);
    push_word(DH_CH0, 0);
    for (int k = 0; k < 3; k++) push_word({$urandom, $urandom}, k == 2);
    wait_done("badhdr");
    check("badhdr_err", err_hdr, 1);
    check("badhdr_pops", pop_cnt, 5);
    check("badhdr_iv", iv_cnt - iv0, 0);
    check("badhdr_err_len", err_len, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("badhdr_clr", err_hdr, 0);

    // Channel beyond DCH
    clear_counts();
    push_word(DH_CH2, 0);
    push_word(DH_CH2, 0);
    for (int k = 0; k < 2; k++) push_word({$urandom, $urandom}, k == 1);
    wait_done("badch");
    check("badch_err", err_hdr, 1);
    check("badch_pops", pop_cnt, 4);
    check("badch_ds", ds0_seen | ds1_seen, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("badch_clr", err_hdr, 0);

    // Short burst: last on word 5
    clear_counts();
    iv0 = iv_cnt; st0 = st_cnt;
    push_burst(5, 64'h8000_0000_0000_00aa, wl);
    wait_done("short");
    check("short_err_len", err_len, 1);
    check("short_iv", iv_cnt - iv0, 0);
    check("short_start", st_cnt - st0, 0);
    check("short_pops", pop_cnt, 7);
    for (int k = 0; k < 6; k++)
      check($sformatf("short_slot%0d", k), instr_bus[64*k +: 64], model[k]);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("short_clr", err_len, 0);

    // Full burst with random FIFO gaps
    clear_counts();
    iv0 = iv_cnt; st0 = st_cnt;
    gaps = 1;
    mast_curr_state = 3'd1;
    push_burst(INUM, 64'h8000_0000_0000_0002, wl);
    wait_iv(iv0 + 1, "stall_iv");
    tick(5);
    mast_curr_state = 3'd0;
    wait_done("stall");
    gaps = 0;
    check("stall_iv_cnt", iv_cnt - iv0, 1);
    check("stall_start_cnt", st_cnt - st0, 1);
    check("stall_slot0_flushed", instr_bus[63:0], 0);
    check("stall_slot15", instr_bus[INUM*64-1 -: 64], wl);
    check("stall_pops", pop_cnt, INUM + 2);
    model[0] = '0;

    // Reset while capturing word 7
    clear_counts();
    iv0 = iv_cnt;
    mast_curr_state = 3'd1;
    push_burst(INUM, 64'h0123_4567_89ab_cdef, wl);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (pop_cnt >= 9) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    if (!ok) check("midrst_timeout", 0, 1);
    reset = 1'b1;
    stream_q.delete();
    exp_bus_q.delete();
    tick(2);
    reset = 1'b0;
    for (int k = 0; k < INUM; k++) model[k] = '0;
    tick(1);
    check("midrst_busy", busy, 0);
    check("midrst_bus_zero", |instr_bus, 0);
    check("midrst_iv", iv_cnt - iv0, 0);

    // Clean burst after reset; slot0[63]=0 so no start pulse
    clear_counts();
    iv0 = iv_cnt; st0 = st_cnt;
    mast_curr_state = 3'd0;
    push_burst(INUM, 64'h0000_0000_0000_1234, wl);
    wait_iv(iv0 + 1, "post_iv");
    wait_done("post");
    check("post_iv_cnt", iv_cnt - iv0, 1);
    check("post_start_cnt", st_cnt - st0, 0);
    check("post_slot15", instr_bus[INUM*64-1 -: 64], wl);
    check("post_pops", pop_cnt, INUM + 2);
    check("post_exp_left", exp_bus_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
